// File: rtl/adc_emul_burst_ctrl_if.sv
// Word stream from the burst controller to the DMA write engine.
// Each word packs two emulator samples; tlast marks the final word of a burst.
interface adc_emul_burst_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/adc_emul_burst_ctrl.sv
// Burst controller for the ADC emulator ramp source: captures sample pairs, packs them
// into words, buffers them in a show-ahead FIFO and streams them out with last-word marking.
module adc_emul_burst_ctrl #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         burst_words,
  output logic                     busy,
  output logic                     done,
  output logic                     ramp_break,
  output logic                     emul_valid,
  output logic                     emul_ready,
  input  logic [WIDTH-1:0]         emul_link,
  adc_emul_burst_ctrl_if.master    m
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] EN_MAX = (AW+1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   n_q;
  logic [CNT_W-1:0]   wcnt_q;
  logic [CNT_W-1:0]   wcnt_inc;
  logic               pair_q;
  logic [WIDTH-1:0]   even_q;
  logic [2*WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]        wr_q;
  logic [AW:0]        rd_q;
  logic [AW:0]        count;
  logic [AW:0]        count_d;
  logic               busy_q;
  logic               done_q;
  logic               rb_q;
  logic               emul_en;
  logic               push;
  logic               push_last;
  logic               pop;

  assign count     = wr_q - rd_q;
  // Two slots of headroom: a pair in flight can always land even if the consumer stalls.
  assign emul_en   = (state_q == S_RUN) && (count <= EN_MAX);
  assign push      = emul_en && pair_q;
  assign wcnt_inc  = wcnt_q + 1'b1;
  assign push_last = push && (wcnt_inc == n_q);
  assign pop       = m.m_tvalid && m.m_tready;
  assign count_d   = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign emul_valid = emul_en;
  assign emul_ready = emul_en;

  assign m.m_tvalid = (count != '0);
  assign m.m_tdata  = m.m_tvalid ? mem_q[rd_q[AW-1:0]][2*WIDTH-1:0] : '0;
  assign m.m_tlast  = m.m_tvalid & mem_q[rd_q[AW-1:0]][2*WIDTH];

  assign busy       = busy_q;
  assign done       = done_q;
  assign ramp_break = rb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      wcnt_q  <= '0;
      pair_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rb_q    <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      pair_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) begin
        wr_q   <= wr_q + 1'b1;
        wcnt_q <= wcnt_inc;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (emul_en) pair_q <= ~pair_q;
      case (state_q)
        S_IDLE: begin
          if (start && (burst_words != '0)) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            n_q     <= burst_words;
            wcnt_q  <= '0;
            pair_q  <= 1'b0;
            rb_q    <= 1'b0;
          end
        end
        S_RUN: begin
          // A back-pressure pause resets the emulator ramp, so it is flagged.
          if (push_last) state_q <= S_DRAIN;
          else if (emul_en && (count_d > EN_MAX)) rb_q <= 1'b1;
        end
        S_DRAIN: begin
          if (pop && m.m_tlast) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (emul_en && !pair_q) even_q <= emul_link;
    if (push) mem_q[wr_q[AW-1:0]] <= {push_last, emul_link, even_q};
  end

endmodule

// File: tb/tb_adc_emul_burst_ctrl.sv
// Bench for adc_emul_burst_ctrl: triangle-ramp emulator, queue-based burst model,
// per-cycle output comparison plus literal checks on the directed scenarios.
module tb_adc_emul_burst_ctrl;
  localparam int D = 16;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] burst_words;
  logic        busy, done, ramp_break, emul_valid, emul_ready;
  logic [15:0] emul_link;

  adc_emul_burst_ctrl_if #(.WIDTH(16)) bus ();

  adc_emul_burst_ctrl #(.WIDTH(16), .FIFO_DEPTH(D), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .burst_words(burst_words),
    .busy(busy), .done(done), .ramp_break(ramp_break), .emul_valid(emul_valid),
    .emul_ready(emul_ready), .emul_link(emul_link), .m(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Triangle ramp: counts up to 0x7FFF, then back down.
  function automatic logic [15:0] ramp16(int a);
    int p;
    p = a % 65534;
    if (p <= 32767) return 16'(p);
    return 16'(65534 - p);
  endfunction

  // Emulator: restarts from zero after any cycle without valid&&ready.
  int emu_acc = 0;
  bit emu_e;
  assign emul_link = ramp16(emu_acc);
  initial forever begin
    @(posedge clk);
    emu_e = emul_valid && emul_ready;
    #1;
    emu_acc = emu_e ? emu_acc + 1 : 0;
  end

  // Behavioural model
  bit          active = 0;
  int          n_m = 0;
  int          pushed = 0;
  int          half = -1;
  int          acc_m = 0;
  bit          rb_m = 0;
  bit          done_m = 0;
  logic [32:0] q[$];
  logic [32:0] m_item;
  bit          m_en, m_pre;
  logic [15:0] m_lk;

  function automatic bit exp_en();
    return active && (pushed < n_m) && (q.size() <= D - 2);
  endfunction

  always @(posedge clk) begin
    m_en  = exp_en();
    m_lk  = ramp16(acc_m);
    m_pre = active;
    acc_m = m_en ? acc_m + 1 : 0;
    if (reset || abort) begin
      active = 0; q.delete(); pushed = 0; half = -1; done_m = 0;
      if (reset) rb_m = 0;
    end else begin
      done_m = 0;
      if (q.size() > 0 && bus.m_tready) begin
        m_item = q.pop_front();
        if (m_item[32]) begin active = 0; done_m = 1; end
      end
      if (m_en) begin
        if (half < 0) half = int'(m_lk);
        else begin
          q.push_back({(pushed + 1 == n_m), m_lk, half[15:0]});
          pushed++;
          half = -1;
        end
      end
      if (m_en && active && pushed < n_m && q.size() > D - 2) rb_m = 1;
      if (!m_pre && start && burst_words != 16'd0) begin
        active = 1; n_m = int'(burst_words); pushed = 0; rb_m = 0; half = -1;
      end
    end
  end

  bit          chk_on = 0;
  logic [31:0] got[$];
  bit          got_last[$];
  int          en_cycles = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("emul_valid", 64'(emul_valid), 64'(exp_en()));
      chk("emul_ready", 64'(emul_ready), 64'(exp_en()));
      chk("m_tvalid", 64'(bus.m_tvalid), 64'(q.size() > 0));
      chk("m_tdata", 64'(bus.m_tdata), (q.size() > 0) ? 64'(q[0][31:0]) : 64'd0);
      chk("m_tlast", 64'(bus.m_tlast), (q.size() > 0) ? 64'(q[0][32]) : 64'd0);
      chk("busy", 64'(busy), 64'(active));
      chk("done", 64'(done), 64'(done_m));
      chk("ramp_break", 64'(ramp_break), 64'(rb_m));
      if (bus.m_tvalid && bus.m_tready) begin
        got.push_back(bus.m_tdata);
        got_last.push_back(bus.m_tlast);
      end
      if (emul_valid) en_cycles++;
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(int n);
    burst_words = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; burst_words = '0; bus.m_tready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk_on = 1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("rst_emul_valid", 64'(emul_valid), 64'd0);

    // Basic burst of four words, consumer always ready
    got.delete(); got_last.delete(); en_cycles = 0; done_cnt = 0;
    bus.m_tready = 1'b1;
    start_burst(4);
    wait_idle(100);
    tick(); tick();
    chk("t1_words", 64'(got.size()), 64'd4);
    if (got.size() == 4) begin
      chk("t1_w0", 64'(got[0]), 64'h0001_0000);
      chk("t1_w1", 64'(got[1]), 64'h0003_0002);
      chk("t1_w2", 64'(got[2]), 64'h0005_0004);
      chk("t1_w3", 64'(got[3]), 64'h0007_0006);
      chk("t1_last3", 64'(got_last[3]), 64'd1);
      chk("t1_last0", 64'(got_last[0]), 64'd0);
    end
    chk("t1_en_cycles", 64'(en_cycles), 64'd8);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_ramp_break", 64'(ramp_break), 64'd0);

    // Back-pressure until the FIFO holds 15 words
    got.delete(); got_last.delete();
    bus.m_tready = 1'b0;
    start_burst(20);
    repeat (40) tick();
    chk("t2_en_low", 64'(emul_valid), 64'd0);
    chk("t2_ramp_break", 64'(ramp_break), 64'd1);
    bus.m_tready = 1'b1;
    wait_idle(200);
    tick();
    chk("t2_words", 64'(got.size()), 64'd20);
    if (got.size() == 20) begin
      chk("t2_w15", 64'(got[14]), 64'h001D_001C);
      chk("t2_w16", 64'(got[15]), 64'h0001_0000);
      chk("t2_last20", 64'(got_last[19]), 64'd1);
    end

    // Abort in the third RUN cycle
    got.delete(); got_last.delete(); done_cnt = 0;
    bus.m_tready = 1'b0;
    start_burst(8);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_en", 64'(emul_valid), 64'd0);
    chk("t3_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    repeat (5) tick();
    chk("t3_no_done", 64'(done_cnt), 64'd0);
    bus.m_tready = 1'b1;
    start_burst(1);
    wait_idle(50);
    tick();
    chk("t3_words", 64'(got.size()), 64'd1);
    if (got.size() == 1) begin
      chk("t3_w0", 64'(got[0]), 64'h0001_0000);
      chk("t3_last", 64'(got_last[0]), 64'd1);
    end

    // Ignored starts
    burst_words = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_zero_busy", 64'(busy), 64'd0);
    got.delete(); got_last.delete();
    start_burst(3);
    tick();
    burst_words = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(100);
    tick();
    chk("t4_words", 64'(got.size()), 64'd3);
    if (got.size() == 3) chk("t4_last", 64'(got_last[2]), 64'd1);

    // Reset in DRAIN with a stalled consumer and ramp_break set
    got.delete(); got_last.delete();
    bus.m_tready = 1'b0;
    start_burst(16);
    repeat (40) tick();
    bus.m_tready = 1'b1;
    repeat (3) tick();
    bus.m_tready = 1'b0;
    repeat (10) tick();
    chk("t5_busy", 64'(busy), 64'd1);
    chk("t5_en", 64'(emul_valid), 64'd0);
    chk("t5_rb", 64'(ramp_break), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy0", 64'(busy), 64'd0);
    chk("t5_done0", 64'(done), 64'd0);
    chk("t5_rb0", 64'(ramp_break), 64'd0);
    chk("t5_ev0", 64'(emul_valid), 64'd0);
    chk("t5_er0", 64'(emul_ready), 64'd0);
    chk("t5_tv0", 64'(bus.m_tvalid), 64'd0);
    chk("t5_td0", 64'(bus.m_tdata), 64'd0);
    chk("t5_tl0", 64'(bus.m_tlast), 64'd0);
    bus.m_tready = 1'b1;
    repeat (3) tick();
    chk("t5_fifo_empty", 64'(got.size()), 64'd3);

    // Ramp turnaround
    got.delete(); got_last.delete();
    start_burst(16385);
    wait_idle(40000);
    tick();
    chk("t6_words", 64'(got.size()), 64'd16385);
    if (got.size() == 16385) begin
      chk("t6_w16384", 64'(got[16383]), 64'h7FFF_7FFE);
      chk("t6_w16385", 64'(got[16384]), 64'h7FFD_7FFE);
      chk("t6_last", 64'(got_last[16384]), 64'd1);
    end
    chk("t6_rb", 64'(ramp_break), 64'd0);

    // Randomized bursts: random length, stalls, stray starts and aborts
    for (int b = 0; b < 14; b++) begin
      start_burst($urandom_range(1, 40));
      for (int c = 0; c < 400 && busy; c++) begin
        bus.m_tready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 30) == 0);
        burst_words = 16'($urandom_range(0, 50));
        abort = ($urandom_range(0, 199) == 0);
        tick();
      end
      start = 1'b0; abort = 1'b0;
      bus.m_tready = 1'b1;
      wait_idle(200);
      repeat ($urandom_range(0, 4)) tick();
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
